// File: rtl/pixel_stream_serializer_pkg.sv
// Shared types and elaboration-time helpers for the pixel stream serializer.
package pixel_stream_pkg;

    // Frame-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of pixels packed into one input beat.
    function automatic int calc_pix_per_beat(input int bus_width, input int pix_width);
        return bus_width / pix_width;
    endfunction

    // Number of input beats that make up one full frame.
    function automatic int calc_total_beats(input int rows, input int cols, input int pix_per_beat);
        return (rows * cols) / pix_per_beat;
    endfunction

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Parameter legality; evaluated at elaboration by the top level.
    function automatic bit params_ok(input int rows, input int cols, input int bus_width,
                                     input int pix_width, input int out_pix);
        int ppb;
        if (rows < 1 || cols < 1 || out_pix < 1) begin
            return 1'b0;
        end
        if (pix_width != 8 && pix_width != 16) begin
            return 1'b0;
        end
        if ((bus_width % pix_width) != 0) begin
            return 1'b0;
        end
        ppb = bus_width / pix_width;
        if ((ppb % out_pix) != 0) begin
            return 1'b0;
        end
        if ((cols % out_pix) != 0) begin
            return 1'b0;
        end
        if (((rows * cols) % ppb) != 0) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/pixel_stream_serializer_if.sv
// Stream bus of the serializer: wide input beats in, narrow pixel beats out.
interface pixel_stream_serializer_if #(
    parameter int BUS_WIDTH = 128,
    parameter int OUT_WIDTH = 8
);
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [BUS_WIDTH-1:0] s_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [OUT_WIDTH-1:0] m_axis_tdata;
    logic                 m_axis_tuser;
    logic                 m_axis_tlast;
    logic                 m_axis_teof;

    // Serializer side.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata,
               m_axis_tuser, m_axis_tlast, m_axis_teof
    );

    // Environment side: beat source and pixel sink.
    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata,
               m_axis_tuser, m_axis_tlast, m_axis_teof
    );
endinterface

// File: rtl/pixel_stream_serializer_beat_slot_buffer.sv
// ACTIVE/NEXT beat pair: ACTIVE shifts out OUT_PIX pixels per handshake,
// NEXT holds a prefetched beat so ACTIVE can reload without a bubble.
module beat_slot_buffer
    import pixel_stream_pkg::*;
#(
    parameter int BUS_WIDTH = 128,
    parameter int PIX_WIDTH = 8,
    parameter int OUT_PIX   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_clear,
    input  logic                           i_load,
    input  logic [BUS_WIDTH-1:0]           i_data,
    input  logic                           i_shift,
    output logic [OUT_PIX*PIX_WIDTH-1:0]   o_data,
    output logic                           o_active_valid,
    output logic                           o_active_last,
    output logic                           o_next_full
);
    localparam int OUT_W  = OUT_PIX * PIX_WIDTH;
    localparam int GROUPS = BUS_WIDTH / OUT_W;
    localparam int GW     = $clog2(GROUPS + 1);

    logic [BUS_WIDTH-1:0] r_active;
    logic [BUS_WIDTH-1:0] r_next;
    logic [GW-1:0]        r_groups;
    logic                 r_next_full;
    logic                 w_drain;
    logic                 w_active_empty;
    logic [BUS_WIDTH-1:0] w_shifted;

    assign w_active_empty = (r_groups == GW'(0));
    assign w_drain        = i_shift && (r_groups == GW'(1));
    assign w_shifted      = r_active >> OUT_W;

    // ACTIVE slot: reload from NEXT or the input on drain, otherwise shift or fill when empty.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_active <= {BUS_WIDTH{1'b0}};
            r_groups <= GW'(0);
        end else if (w_drain && r_next_full) begin
            r_active <= r_next;
            r_groups <= GW'(GROUPS);
        end else if (w_drain && i_load) begin
            r_active <= i_data;
            r_groups <= GW'(GROUPS);
        end else if (i_shift) begin
            r_active <= w_shifted;
            r_groups <= r_groups - GW'(1);
        end else if (i_load && w_active_empty) begin
            r_active <= i_data;
            r_groups <= GW'(GROUPS);
        end else begin
            r_active <= r_active;
            r_groups <= r_groups;
        end
    end

    // NEXT slot: takes the input whenever ACTIVE is busy; empties when it moves into ACTIVE.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_next      <= {BUS_WIDTH{1'b0}};
            r_next_full <= 1'b0;
        end else if (w_drain && r_next_full) begin
            r_next      <= i_load ? i_data : r_next;
            r_next_full <= i_load;
        end else if (i_load && !w_drain && !w_active_empty) begin
            r_next      <= i_data;
            r_next_full <= 1'b1;
        end else begin
            r_next      <= r_next;
            r_next_full <= r_next_full;
        end
    end

    assign o_data         = r_active[OUT_W-1:0];
    assign o_active_valid = !w_active_empty;
    assign o_active_last  = (r_groups == GW'(1));
    assign o_next_full    = r_next_full;

endmodule

// File: rtl/pixel_stream_serializer.sv
// Wide-beat to narrow-pixel serializer with frame sideband and ap_* control.
module pixel_stream_serializer
    import pixel_stream_pkg::*;
#(
    parameter int IN_ROWS   = 20,
    parameter int IN_COLS   = 20,
    parameter int BUS_WIDTH = 128,
    parameter int PIX_WIDTH = 8,
    parameter int OUT_PIX   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_idle,
    output logic                          ap_done,
    pixel_stream_serializer_if.slave      bus,
    output logic [cnt_width(IN_COLS)-1:0] cnt_col,
    output logic [cnt_width(IN_ROWS)-1:0] cnt_row
);
    localparam int PIX_PER_BEAT = calc_pix_per_beat(BUS_WIDTH, PIX_WIDTH);
    localparam int TOTAL_BEATS  = calc_total_beats(IN_ROWS, IN_COLS, PIX_PER_BEAT);
    localparam int OUT_W        = OUT_PIX * PIX_WIDTH;
    localparam int CW           = cnt_width(IN_COLS);
    localparam int RW           = cnt_width(IN_ROWS);
    localparam int BW           = $clog2(TOTAL_BEATS + 1);

    if (!params_ok(IN_ROWS, IN_COLS, BUS_WIDTH, PIX_WIDTH, OUT_PIX)) begin : g_param_check
        $error("pixel_stream_serializer: illegal parameter combination");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic             r_ap_idle;
    logic             r_ap_done;
    logic [BW-1:0]    r_beats;
    logic [CW-1:0]    r_cnt_col;
    logic [RW-1:0]    r_cnt_row;
    logic             w_act_valid;
    logic             w_act_last;
    logic             w_next_full;
    logic             w_next_moving;
    logic             w_s_tready;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_col_wrap;
    logic             w_row_last;
    logic             w_teof;
    logic             w_clear;
    logic [OUT_W-1:0] w_out_data;

    assign w_out_hs      = w_act_valid && bus.m_axis_tready;
    assign w_next_moving = w_out_hs && w_act_last && w_next_full;
    assign w_s_tready    = (r_state == RUN) && (!w_next_full || w_next_moving)
                           && (r_beats < BW'(TOTAL_BEATS));
    assign w_in_hs       = bus.s_axis_tvalid && w_s_tready;
    assign w_col_wrap    = (r_cnt_col == CW'(IN_COLS - OUT_PIX));
    assign w_row_last    = (r_cnt_row == RW'(IN_ROWS - 1));
    assign w_teof        = w_col_wrap && w_row_last;
    // The teof handshake is the RUN->DONE transition; slots and counters restart there.
    assign w_clear       = (r_state == RUN) && (w_next_state == DONE);

    beat_slot_buffer #(
        .BUS_WIDTH (BUS_WIDTH),
        .PIX_WIDTH (PIX_WIDTH),
        .OUT_PIX   (OUT_PIX)
    ) u_slots (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_clear),
        .i_load         (w_in_hs),
        .i_data         (bus.s_axis_tdata),
        .i_shift        (w_out_hs),
        .o_data         (w_out_data),
        .o_active_valid (w_act_valid),
        .o_active_last  (w_act_last),
        .o_next_full    (w_next_full)
    );

    // Next-state decode; ap_start only matters while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_out_hs && w_teof) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered ap_* status, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ap_idle <= 1'b1;
            r_ap_done <= 1'b0;
        end else begin
            r_ap_idle <= (w_next_state == IDLE);
            r_ap_done <= (w_next_state == DONE);
        end
    end

    // Input beats accepted this frame; caps acceptance at the frame size.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_beats <= BW'(0);
        end else if (w_in_hs) begin
            r_beats <= r_beats + BW'(1);
        end else begin
            r_beats <= r_beats;
        end
    end

    // Column/row position of lane 0, advanced per output handshake.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_cnt_col <= CW'(0);
            r_cnt_row <= RW'(0);
        end else if (w_out_hs) begin
            if (w_col_wrap) begin
                r_cnt_col <= CW'(0);
                r_cnt_row <= w_row_last ? RW'(0) : (r_cnt_row + RW'(1));
            end else begin
                r_cnt_col <= r_cnt_col + CW'(OUT_PIX);
                r_cnt_row <= r_cnt_row;
            end
        end else begin
            r_cnt_col <= r_cnt_col;
            r_cnt_row <= r_cnt_row;
        end
    end

    assign ap_ready          = r_ap_idle;
    assign ap_idle           = r_ap_idle;
    assign ap_done           = r_ap_done;
    assign cnt_col           = r_cnt_col;
    assign cnt_row           = r_cnt_row;
    assign bus.s_axis_tready = w_s_tready;
    assign bus.m_axis_tvalid = w_act_valid;
    assign bus.m_axis_tdata  = w_out_data;
    // Sideband is qualified by valid so it reads 0 between frames.
    assign bus.m_axis_tuser  = w_act_valid && (r_cnt_row == RW'(0)) && (r_cnt_col == CW'(0));
    assign bus.m_axis_tlast  = w_act_valid && w_col_wrap;
    assign bus.m_axis_teof   = w_act_valid && w_teof;

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// Directed bench: 4x32 Mono8 instance (A) and 2x16 16-bit/4-lane instance (B).
module tb_pixel_stream_serializer;
    logic clk = 1'b0;
    logic reset;
    logic ap_start_a, ap_ready_a, ap_idle_a, ap_done_a;
    logic ap_start_b, ap_ready_b, ap_idle_b, ap_done_b;
    logic [4:0] cnt_col_a;
    logic [1:0] cnt_row_a;
    logic [3:0] cnt_col_b;
    logic [0:0] cnt_row_b;

    int n_pass = 0;
    int n_fail = 0;
    int n_checks = 0;
    logic [7:0]  exp_q[$];
    logic [63:0] exp_qb[$];

    always #5 clk = ~clk;

    pixel_stream_serializer_if #(.BUS_WIDTH(128), .OUT_WIDTH(8))  if_a ();
    pixel_stream_serializer_if #(.BUS_WIDTH(128), .OUT_WIDTH(64)) if_b ();

    pixel_stream_serializer #(
        .IN_ROWS(4), .IN_COLS(32), .BUS_WIDTH(128), .PIX_WIDTH(8), .OUT_PIX(1)
    ) dut_a (
        .clk(clk), .reset(reset), .ap_start(ap_start_a), .ap_ready(ap_ready_a),
        .ap_idle(ap_idle_a), .ap_done(ap_done_a), .bus(if_a),
        .cnt_col(cnt_col_a), .cnt_row(cnt_row_a)
    );

    pixel_stream_serializer #(
        .IN_ROWS(2), .IN_COLS(16), .BUS_WIDTH(128), .PIX_WIDTH(16), .OUT_PIX(4)
    ) dut_b (
        .clk(clk), .reset(reset), .ap_start(ap_start_b), .ap_ready(ap_ready_b),
        .ap_idle(ap_idle_b), .ap_done(ap_done_b), .bus(if_b),
        .cnt_col(cnt_col_b), .cnt_row(cnt_row_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_ap_ready"}, ap_ready_a, 1);
        check({tag, "_ap_idle"},  ap_idle_a, 1);
        check({tag, "_ap_done"},  ap_done_a, 0);
        check({tag, "_s_tready"}, if_a.s_axis_tready, 0);
        check({tag, "_m_tvalid"}, if_a.m_axis_tvalid, 0);
        check({tag, "_flags"},    {if_a.m_axis_tuser, if_a.m_axis_tlast, if_a.m_axis_teof}, 0);
        check({tag, "_tdata"},    if_a.m_axis_tdata, 0);
        check({tag, "_cnt"},      {cnt_row_a, cnt_col_a}, 0);
    endtask

    // One frame on instance A; returns early at the negedge where stop_at pixels have left.
    task automatic run_frame_a(input int rdy_pct, input int vld_pct, input bit extra,
                               input int stop_at, input bit poke_start);
        int accepted, out_pix, phase, cyc, gaps, dones;
        bit seen_valid, stall_prev, full;
        logic [7:0] hold_data, exp_pix;
        logic [2:0] hold_flags;
        logic [6:0] hold_cnt;
        accepted = 0; out_pix = 0; phase = 0; cyc = 0; gaps = 0; dones = 0;
        seen_valid = 0; stall_prev = 0;
        full = (rdy_pct >= 100) && (vld_pct >= 100);
        hold_data = '0; hold_flags = '0; hold_cnt = '0;
        exp_q.delete();
        ap_start_a = 1'b1;
        #1;
        check("start_ap_ready", ap_ready_a, 1);
        check("start_s_tready", if_a.s_axis_tready, 0);
        @(posedge clk);
        @(negedge clk);
        while (phase < 3 && cyc < 3000) begin
            if (stop_at >= 0 && out_pix == stop_at) begin
                ap_start_a = 1'b0;
                if_a.s_axis_tvalid = 1'b0;
                if_a.m_axis_tready = 1'b0;
                return;
            end
            if_a.m_axis_tready = ($urandom_range(99) < rdy_pct);
            if_a.s_axis_tvalid = ((accepted < 8) || extra) && ($urandom_range(99) < vld_pct);
            for (int p = 0; p < 16; p++) if_a.s_axis_tdata[p*8 +: 8] = 8'(accepted * 16 + p);
            ap_start_a = poke_start && (phase == 0) && (out_pix < 100) && ($urandom_range(3) == 0);
            #1;
            if (stall_prev) begin
                check("stall_tvalid", if_a.m_axis_tvalid, 1);
                check("stall_tdata", if_a.m_axis_tdata, hold_data);
                check("stall_flags", {if_a.m_axis_tuser, if_a.m_axis_tlast, if_a.m_axis_teof}, hold_flags);
                check("stall_cnt", {cnt_row_a, cnt_col_a}, hold_cnt);
            end
            if (if_a.s_axis_tvalid && accepted >= 8) check("over_s_tready", if_a.s_axis_tready, 0);
            if (if_a.s_axis_tvalid && if_a.s_axis_tready) begin
                for (int p = 0; p < 16; p++) exp_q.push_back(8'(accepted * 16 + p));
                accepted++;
            end
            if (ap_done_a) dones++;
            if (phase == 0) begin
                if (if_a.m_axis_tvalid) seen_valid = 1;
                else if (seen_valid && full) gaps++;
                if (if_a.m_axis_tvalid && if_a.m_axis_tready) begin
                    if (exp_q.size() > 0) exp_pix = exp_q.pop_front();
                    else exp_pix = 'x;
                    check("a_tdata", if_a.m_axis_tdata, exp_pix);
                    check("a_tuser", if_a.m_axis_tuser, out_pix == 0);
                    check("a_tlast", if_a.m_axis_tlast, (out_pix % 32) == 31);
                    check("a_teof", if_a.m_axis_teof, out_pix == 127);
                    check("a_cnt_col", cnt_col_a, out_pix % 32);
                    check("a_cnt_row", cnt_row_a, out_pix / 32);
                    out_pix++;
                    if (out_pix == 128) begin
                        phase = 1;
                        if (full) check("a_frame_cycles", cyc, 128);
                    end
                end
                stall_prev = if_a.m_axis_tvalid && !if_a.m_axis_tready;
                hold_data  = if_a.m_axis_tdata;
                hold_flags = {if_a.m_axis_tuser, if_a.m_axis_tlast, if_a.m_axis_teof};
                hold_cnt   = {cnt_row_a, cnt_col_a};
            end else if (phase == 1) begin
                check("a_done_pulse", ap_done_a, 1);
                check("a_done_not_ready", ap_ready_a, 0);
                stall_prev = 0;
                phase = 2;
            end else begin
                check("a_ready_back", ap_ready_a, 1);
                check("a_done_low", ap_done_a, 0);
                phase = 3;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        ap_start_a = 1'b0;
        if_a.s_axis_tvalid = 1'b0;
        if_a.m_axis_tready = 1'b0;
        check("a_frame_timeout", cyc < 3000, 1);
        check("a_frame_pixels", out_pix, 128);
        check("a_beats_accepted", accepted, 8);
        check("a_done_count", dones, 1);
        if (full) check("a_no_gaps", gaps, 0);
    endtask

    // One frame on instance B with both sides always ready.
    task automatic run_frame_b();
        int accepted, out_beat, phase, cyc;
        logic [63:0] w, exp_w;
        accepted = 0; out_beat = 0; phase = 0; cyc = 0;
        exp_qb.delete();
        ap_start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ap_start_b = 1'b0;
        while (phase < 2 && cyc < 500) begin
            if_b.m_axis_tready = 1'b1;
            if_b.s_axis_tvalid = (accepted < 4);
            for (int p = 0; p < 8; p++) if_b.s_axis_tdata[p*16 +: 16] = 16'(accepted * 8 + p);
            #1;
            if (if_b.s_axis_tvalid && if_b.s_axis_tready) begin
                for (int h = 0; h < 2; h++) begin
                    w = '0;
                    for (int j = 0; j < 4; j++) w[j*16 +: 16] = 16'(accepted * 8 + h * 4 + j);
                    exp_qb.push_back(w);
                end
                accepted++;
            end
            if (phase == 0 && if_b.m_axis_tvalid && if_b.m_axis_tready) begin
                if (exp_qb.size() > 0) exp_w = exp_qb.pop_front();
                else exp_w = 'x;
                check("b_tdata", if_b.m_axis_tdata, exp_w);
                if (out_beat == 0) check("b_beat0", if_b.m_axis_tdata, 64'h0003_0002_0001_0000);
                check("b_cnt_col", cnt_col_b, (out_beat % 4) * 4);
                check("b_cnt_row", cnt_row_b, out_beat / 4);
                check("b_tlast", if_b.m_axis_tlast, (out_beat % 4) == 3);
                check("b_teof", if_b.m_axis_teof, out_beat == 7);
                check("b_tuser", if_b.m_axis_tuser, out_beat == 0);
                out_beat++;
                if (out_beat == 8) phase = 1;
            end else if (phase == 1) begin
                check("b_done_pulse", ap_done_b, 1);
                phase = 2;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if_b.s_axis_tvalid = 1'b0;
        if_b.m_axis_tready = 1'b0;
        check("b_beats", out_beat, 8);
        check("b_cnt_col_wrapped", cnt_col_b, 0);
        check("b_ready_back", ap_ready_b, 1);
    endtask

    initial begin
        reset = 1'b1;
        ap_start_a = 1'b0;
        ap_start_b = 1'b0;
        if_a.s_axis_tvalid = 1'b0; if_a.s_axis_tdata = '0; if_a.m_axis_tready = 1'b0;
        if_b.s_axis_tvalid = 1'b0; if_b.s_axis_tdata = '0; if_b.m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("rst");
        check("rst_b_idle", {ap_idle_b, if_b.m_axis_tvalid, if_b.m_axis_tdata == 64'd0}, 3'b101);
        reset = 1'b0;
        @(negedge clk);
        run_frame_a(100, 100, 1'b0, -1, 1'b0);
        run_frame_b();
        run_frame_a(50, 60, 1'b0, -1, 1'b0);
        run_frame_a(50, 100, 1'b1, -1, 1'b0);
        run_frame_a(100, 100, 1'b0, 50, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_a("midrst");
        reset = 1'b0;
        @(negedge clk);
        run_frame_a(100, 100, 1'b0, -1, 1'b0);
        run_frame_a(70, 80, 1'b0, -1, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
